kawiarka_actuator_ctrl: RTL and testbench



---
 rtl/kawiarka_pkg.sv | 18 +
 rtl/kawiarka_sync_2ff.sv | 24 ++
 rtl/kawiarka_actuator_ctrl.sv | 128 ++++++++++++
 tb/tb_kawiarka_actuator_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/kawiarka_pkg.sv
// Shared definitions for the kawiarka coffee-maker: upstream phase codes and
// the actuator controller state encoding.
package kawiarka_pkg;

    localparam logic [1:0] CODE_READY  = 2'b01;
    localparam logic [1:0] CODE_HEAT   = 2'b10;
    localparam logic [1:0] CODE_BREW   = 2'b11;
    localparam logic [1:0] CODE_FINISH = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PREHEAT   = 3'd1,
        ST_BREW      = 3'd2,
        ST_DONE_BEEP = 3'd3,
        ST_FAULT     = 3'd4
    } act_state_t;

endpackage

// File: rtl/kawiarka_sync_2ff.sv
// Single-bit two-flop synchronizer for asynchronous sensor inputs
// (thermostat, water level); clears to 0 on reset.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: sequential state uses non-blocking assignments so both flops sample
    // the pre-edge values and the chain really is two stages deep.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/kawiarka_actuator_ctrl.sv
// Actuator controller: turns the upstream phase code into heater/pump/buzzer/LED
// drive, with thermostat and water interlocks, phase timing and a sticky fault.
module kawiarka_actuator_ctrl #(
    parameter int HEAT_TIMEOUT = 1000,
    parameter int BREW_CYCLES  = 500,
    parameter int BEEP_CYCLES  = 50,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] mode_code,
    input  logic       temp_ok,
    input  logic       water_ok,
    input  logic       fault_clr,
    output logic       heater_en,
    output logic       pump_en,
    output logic       buzzer,
    output logic       ready_led,
    output logic       fault
);

    import kawiarka_pkg::*;

    localparam logic [CNT_W-1:0] HEAT_LAST = CNT_W'(HEAT_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] BREW_LAST = CNT_W'(BREW_CYCLES - 1);
    localparam logic [CNT_W-1:0] BEEP_LAST = CNT_W'(BEEP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    act_state_t       state, next_state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       code_q1, code_q2;
    logic             temp_s, water_s;
    logic             acc;

    sync_2ff u_sync_temp  (.clk(clk), .reset(reset), .d(temp_ok),  .q(temp_s));
    sync_2ff u_sync_water (.clk(clk), .reset(reset), .d(water_ok), .q(water_s));

    // Two-stage code pipe: a code is trusted only once it has been seen on two
    // consecutive edges, which rejects single-cycle glitches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            code_q1 <= CODE_READY;
            code_q2 <= CODE_READY;
        end else begin
            code_q1 <= mode_code;
            code_q2 <= code_q1;
        end
    end

    assign acc = (code_q1 == code_q2);

    // NOTE: next_state gets its default before the case so every path assigns
    // it and no latch is inferred.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (acc && code_q2 == CODE_HEAT)
                    next_state = water_s ? ST_PREHEAT : ST_FAULT;
            end
            ST_PREHEAT: begin
                if (!water_s)
                    next_state = ST_FAULT;
                else if (cnt == HEAT_LAST && !temp_s)
                    next_state = ST_FAULT;
                else if (acc && code_q2 == CODE_BREW && temp_s)
                    next_state = ST_BREW;
                else if (acc && code_q2 == CODE_READY)
                    next_state = ST_IDLE;
            end
            ST_BREW: begin
                if (!water_s)
                    next_state = ST_FAULT;
                else if (cnt == BREW_LAST)
                    next_state = ST_DONE_BEEP;
                else if (acc) begin
                    case (code_q2)
                        CODE_FINISH: next_state = ST_DONE_BEEP;
                        CODE_HEAT:   next_state = ST_PREHEAT;
                        CODE_READY:  next_state = ST_IDLE;
                        default:     next_state = ST_BREW;
                    endcase
                end
            end
            ST_DONE_BEEP: begin
                if (cnt == BEEP_LAST)
                    next_state = ST_IDLE;
            end
            ST_FAULT: begin
                if (fault_clr && acc && code_q2 == CODE_READY)
                    next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            if (next_state != state)
                cnt <= '0;
            else if (cnt != CNT_MAX)
                cnt <= cnt + 1'b1;
        end
    end

    // Outputs are registered from next_state so they change on the same edge as
    // state; in BREW the heater follows the thermostat (bang-bang).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            heater_en <= 1'b0;
            pump_en   <= 1'b0;
            buzzer    <= 1'b0;
            ready_led <= 1'b1;
            fault     <= 1'b0;
        end else begin
            heater_en <= (next_state == ST_PREHEAT) || (next_state == ST_BREW && !temp_s);
            pump_en   <= (next_state == ST_BREW);
            buzzer    <= (next_state == ST_DONE_BEEP);
            ready_led <= (next_state == ST_IDLE);
            fault     <= (next_state == ST_FAULT);
        end
    end

endmodule

// File: tb/tb_kawiarka_actuator_ctrl.sv
// Directed bench for kawiarka_actuator_ctrl with short timing parameters;
// outputs are compared as {heater_en, pump_en, buzzer, ready_led, fault}.
module tb_kawiarka_actuator_ctrl;

    logic       clk;
    logic       reset;
    logic [1:0] mode_code;
    logic       temp_ok;
    logic       water_ok;
    logic       fault_clr;
    logic       heater_en, pump_en, buzzer, ready_led, fault;

    int checks = 0;
    int errors = 0;

    localparam logic [4:0] O_IDLE  = 5'b00010;
    localparam logic [4:0] O_HEAT  = 5'b10000;
    localparam logic [4:0] O_BREW  = 5'b01000;
    localparam logic [4:0] O_BREWH = 5'b11000;
    localparam logic [4:0] O_BEEP  = 5'b00100;
    localparam logic [4:0] O_FAULT = 5'b00001;

    kawiarka_actuator_ctrl #(
        .HEAT_TIMEOUT(20),
        .BREW_CYCLES (10),
        .BEEP_CYCLES (4),
        .CNT_W       (16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .mode_code(mode_code),
        .temp_ok  (temp_ok),
        .water_ok (water_ok),
        .fault_clr(fault_clr),
        .heater_en(heater_en),
        .pump_en  (pump_en),
        .buzzer   (buzzer),
        .ready_led(ready_led),
        .fault    (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] outs();
        return {heater_en, pump_en, buzzer, ready_led, fault};
    endfunction

    // Advance n rising edges, then settle 1 ns past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; mode_code = 2'b01; temp_ok = 1'b0; water_ok = 1'b1; fault_clr = 1'b0;
        step(2);
        checks++; if (outs() !== O_IDLE) begin errors++; $display("FAIL reset_values got=%b exp=%b", outs(), O_IDLE); end
        reset = 1'b0;
        step(3);
        checks++; if (outs() !== O_IDLE) begin errors++; $display("FAIL reset_release got=%b exp=%b", outs(), O_IDLE); end
    endtask

    task automatic test_normal_cycle();
        mode_code = 2'b10;
        step(2);
        checks++; if (outs() !== O_IDLE) begin errors++; $display("FAIL normal_heat_edge2 got=%b exp=%b", outs(), O_IDLE); end
        step(1);
        checks++; if (outs() !== O_HEAT) begin errors++; $display("FAIL normal_heat_edge3 got=%b exp=%b", outs(), O_HEAT); end
        temp_ok = 1'b1;
        step(7);
        mode_code = 2'b11;
        step(2);
        checks++; if (outs() !== O_HEAT) begin errors++; $display("FAIL normal_brew_edge12 got=%b exp=%b", outs(), O_HEAT); end
        step(1);
        checks++; if (outs() !== O_BREW) begin errors++; $display("FAIL normal_brew_edge13 got=%b exp=%b", outs(), O_BREW); end
        mode_code = 2'b00;
        step(2);
        checks++; if (outs() !== O_BREW) begin errors++; $display("FAIL normal_finish_wait got=%b exp=%b", outs(), O_BREW); end
        for (int i = 0; i < 4; i++) begin
            step(1);
            checks++; if (outs() !== O_BEEP) begin errors++; $display("FAIL normal_beep_%0d got=%b exp=%b", i, outs(), O_BEEP); end
        end
        step(1);
        checks++; if (outs() !== O_IDLE) begin errors++; $display("FAIL normal_back_idle got=%b exp=%b", outs(), O_IDLE); end
        mode_code = 2'b01;
        step(3);
    endtask

    task automatic test_brew_limit();
        mode_code = 2'b10;
        step(3);
        checks++; if (outs() !== O_HEAT) begin errors++; $display("FAIL limit_preheat got=%b exp=%b", outs(), O_HEAT); end
        mode_code = 2'b11;
        step(3);
        checks++; if (outs() !== O_BREW) begin errors++; $display("FAIL limit_brew_start got=%b exp=%b", outs(), O_BREW); end
        for (int i = 1; i < 10; i++) begin
            step(1);
            checks++; if (outs() !== O_BREW) begin errors++; $display("FAIL limit_brew_%0d got=%b exp=%b", i, outs(), O_BREW); end
        end
        for (int i = 0; i < 4; i++) begin
            step(1);
            checks++; if (outs() !== O_BEEP) begin errors++; $display("FAIL limit_beep_%0d got=%b exp=%b", i, outs(), O_BEEP); end
        end
        step(1);
        checks++; if (outs() !== O_IDLE) begin errors++; $display("FAIL limit_idle got=%b exp=%b", outs(), O_IDLE); end
        // Code 11 still held: IDLE must not restart a brew.
        step(3);
        checks++; if (outs() !== O_IDLE) begin errors++; $display("FAIL limit_idle_hold got=%b exp=%b", outs(), O_IDLE); end
        mode_code = 2'b01;
        step(3);
    endtask

    task automatic test_heat_timeout();
        temp_ok = 1'b0;
        step(3);
        mode_code = 2'b10;
        step(3);
        checks++; if (outs() !== O_HEAT) begin errors++; $display("FAIL timeout_preheat got=%b exp=%b", outs(), O_HEAT); end
        for (int i = 1; i < 20; i++) begin
            step(1);
            checks++; if (outs() !== O_HEAT) begin errors++; $display("FAIL timeout_heat_%0d got=%b exp=%b", i, outs(), O_HEAT); end
        end
        step(1);
        checks++; if (outs() !== O_FAULT) begin errors++; $display("FAIL timeout_fault got=%b exp=%b", outs(), O_FAULT); end
        step(4);
        checks++; if (outs() !== O_FAULT) begin errors++; $display("FAIL timeout_sticky got=%b exp=%b", outs(), O_FAULT); end
        fault_clr = 1'b1;
        step(1);
        fault_clr = 1'b0;
        checks++; if (outs() !== O_FAULT) begin errors++; $display("FAIL timeout_clr_wrong_code got=%b exp=%b", outs(), O_FAULT); end
        mode_code = 2'b01;
        step(4);
        checks++; if (outs() !== O_FAULT) begin errors++; $display("FAIL timeout_code_no_clr got=%b exp=%b", outs(), O_FAULT); end
        fault_clr = 1'b1;
        step(1);
        fault_clr = 1'b0;
        checks++; if (outs() !== O_IDLE) begin errors++; $display("FAIL timeout_cleared got=%b exp=%b", outs(), O_IDLE); end
    endtask

    task automatic test_glitch();
        mode_code = 2'b10;
        step(1);
        mode_code = 2'b01;
        for (int i = 0; i < 5; i++) begin
            step(1);
            checks++; if (outs() !== O_IDLE) begin errors++; $display("FAIL glitch_%0d got=%b exp=%b", i, outs(), O_IDLE); end
        end
        mode_code = 2'b11;
        step(4);
        checks++; if (outs() !== O_IDLE) begin errors++; $display("FAIL idle_ignores_brew got=%b exp=%b", outs(), O_IDLE); end
        mode_code = 2'b00;
        step(4);
        checks++; if (outs() !== O_IDLE) begin errors++; $display("FAIL idle_ignores_finish got=%b exp=%b", outs(), O_IDLE); end
        mode_code = 2'b01;
        step(3);
    endtask

    task automatic test_water_loss();
        temp_ok = 1'b1;
        step(3);
        mode_code = 2'b10;
        step(3);
        checks++; if (outs() !== O_HEAT) begin errors++; $display("FAIL water_preheat got=%b exp=%b", outs(), O_HEAT); end
        mode_code = 2'b11;
        step(3);
        checks++; if (outs() !== O_BREW) begin errors++; $display("FAIL water_brew got=%b exp=%b", outs(), O_BREW); end
        water_ok = 1'b0;
        step(2);
        checks++; if (outs() !== O_BREW) begin errors++; $display("FAIL water_sync_delay got=%b exp=%b", outs(), O_BREW); end
        step(1);
        checks++; if (outs() !== O_FAULT) begin errors++; $display("FAIL water_fault got=%b exp=%b", outs(), O_FAULT); end
        water_ok = 1'b1;
        mode_code = 2'b01;
        step(3);
        fault_clr = 1'b1;
        step(1);
        fault_clr = 1'b0;
        checks++; if (outs() !== O_IDLE) begin errors++; $display("FAIL water_cleared got=%b exp=%b", outs(), O_IDLE); end
        // Heat request from IDLE with an empty tank faults immediately.
        water_ok = 1'b0;
        step(3);
        mode_code = 2'b10;
        step(3);
        checks++; if (outs() !== O_FAULT) begin errors++; $display("FAIL dry_start_fault got=%b exp=%b", outs(), O_FAULT); end
        water_ok = 1'b1;
        mode_code = 2'b01;
        step(3);
        fault_clr = 1'b1;
        step(1);
        fault_clr = 1'b0;
        checks++; if (outs() !== O_IDLE) begin errors++; $display("FAIL dry_start_cleared got=%b exp=%b", outs(), O_IDLE); end
    endtask

    task automatic test_async_reset();
        mode_code = 2'b10;
        step(3);
        checks++; if (outs() !== O_HEAT) begin errors++; $display("FAIL areset_preheat got=%b exp=%b", outs(), O_HEAT); end
        mode_code = 2'b11;
        step(3);
        checks++; if (outs() !== O_BREW) begin errors++; $display("FAIL areset_brew got=%b exp=%b", outs(), O_BREW); end
        temp_ok = 1'b0;
        step(3);
        checks++; if (outs() !== O_BREWH) begin errors++; $display("FAIL brew_bang_bang got=%b exp=%b", outs(), O_BREWH); end
        #3 reset = 1'b1;
        #1;
        checks++; if (outs() !== O_IDLE) begin errors++; $display("FAIL areset_immediate got=%b exp=%b", outs(), O_IDLE); end
        #2 reset = 1'b0;
        step(5);
        checks++; if (outs() !== O_IDLE) begin errors++; $display("FAIL areset_idle_hold got=%b exp=%b", outs(), O_IDLE); end
        mode_code = 2'b10;
        step(2);
        checks++; if (outs() !== O_IDLE) begin errors++; $display("FAIL areset_reheat_edge2 got=%b exp=%b", outs(), O_IDLE); end
        step(1);
        checks++; if (outs() !== O_HEAT) begin errors++; $display("FAIL areset_reheat_edge3 got=%b exp=%b", outs(), O_HEAT); end
        mode_code = 2'b01;
        step(3);
        checks++; if (outs() !== O_IDLE) begin errors++; $display("FAIL preheat_cancel got=%b exp=%b", outs(), O_IDLE); end
    endtask

    initial begin
        test_reset();
        test_normal_cycle();
        test_brew_limit();
        test_heat_timeout();
        test_glitch();
        test_water_loss();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
